// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants, FSM encoding and helper functions for the
// hazard/forwarding controller. Optional statistics build: HAZARD_STATS_EN.
package hazard_pkg;

    // Operand-mux select codes for the EX-stage forwarding muxes.
    localparam logic [1:0] FWD_RF  = 2'b00;  // register-file value
    localparam logic [1:0] FWD_WB  = 2'b01;  // WB-stage result
    localparam logic [1:0] FWD_MEM = 2'b10;  // MEM-stage ALU result

    // Controller FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } hz_state_e;

    // A shadow slot is {valid, rs1, rs2, rd, regwrite, memread}.
    // An all-zero slot is an empty (invalid) slot.
    localparam int SLOT_FLAG_W = 3;

    function automatic int slot_width(input int addr_w);
        return 3 * addr_w + SLOT_FLAG_W;
    endfunction

    // Down-counter width: $clog2(max(a,b)) + 1.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m) + 1;
    endfunction

    // Increment that sticks at all-ones.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/hazard_dest_pipe.sv
// hazard_dest_pipe: three-slot shadow pipeline (EX/MEM/WB) of instruction
// register IDs. A bubble loads an empty slot into EX; reset empties all slots.
module hazard_dest_pipe #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bubble,
    input  logic [W-1:0] id_slot,
    output logic [W-1:0] ex_slot,
    output logic [W-1:0] mem_slot,
    output logic [W-1:0] wb_slot
);

    // Advance the shadow slots one stage per clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_slot  <= '0;
            mem_slot <= '0;
            wb_slot  <= '0;
        end else begin
            wb_slot  <= mem_slot;
            mem_slot <= ex_slot;
            ex_slot  <= bubble ? '0 : id_slot;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: operand forwarding selects, load-use stall and taken-branch
// flush control for a 5-stage pipeline.
// Optional feature macro HAZARD_STATS_EN adds saturating event counters.
//
// Handshake note: there is no valid/ready pair here; id_valid qualifies the ID
// inputs in the cycle they are presented, and every output is a level that
// applies to the current cycle (stall/bubble/flush act on the next clock edge).
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W     = 5,
    parameter int LOAD_USE_STALL = 1,
    parameter int FLUSH_CYCLES   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  ex_branch_taken,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall,
    output logic                  bubble,
    output logic                  flush
`ifdef HAZARD_STATS_EN
   ,output logic [31:0]           stall_count,
    output logic [31:0]           flush_count,
    output logic [31:0]           fwd_count
`endif
);

    localparam int CNT_W  = cnt_width(LOAD_USE_STALL, FLUSH_CYCLES);
    localparam int SLOT_W = slot_width(REG_ADDR_W);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic                  memread;
    } slot_t;

    slot_t            id_s;
    slot_t            ex_s;
    slot_t            mem_s;
    slot_t            wb_s;
    hz_state_e        state;
    hz_state_e        state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             rst_q;
    logic             quiet;
    logic             load_use_hit;
    logic             stall_c;
    logic             bubble_c;
    logic             flush_c;
    logic [1:0]       fwd_a_c;
    logic [1:0]       fwd_b_c;
    logic             unused_fields;

    assign id_s = '{valid: id_valid, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                    regwrite: id_regwrite, memread: id_memread};

    // Not every slot field is consumed at every stage.
    assign unused_fields = ^{ex_s, mem_s, wb_s};

    hazard_dest_pipe #(
        .W (SLOT_W)
    ) u_dest_pipe (
        .clk      (clk),
        .rst      (rst),
        .bubble   (bubble_c),
        .id_slot  (id_s),
        .ex_slot  (ex_s),
        .mem_slot (mem_s),
        .wb_slot  (wb_s)
    );

    // Source for one operand: MEM beats WB; x0 and non-writers never forward.
    function automatic logic [1:0] fwd_pick(input logic [REG_ADDR_W-1:0] rs,
                                            input slot_t m, input slot_t w);
        if (rs == '0)
            return FWD_RF;
        if (m.valid && m.regwrite && (m.rd == rs))
            return FWD_MEM;
        if (w.valid && w.regwrite && (w.rd == rs))
            return FWD_WB;
        return FWD_RF;
    endfunction

    // Outputs are held quiet in the reset cycle and the cycle after it.
    always_ff @(posedge clk) begin
        rst_q <= rst;
    end

    assign quiet = rst | rst_q;

    // Forwarding selects for the instruction currently in EX.
    always_comb begin
        fwd_a_c = FWD_RF;
        fwd_b_c = FWD_RF;
        if (ex_s.valid) begin
            fwd_a_c = fwd_pick(ex_s.rs1, mem_s, wb_s);
            fwd_b_c = fwd_pick(ex_s.rs2, mem_s, wb_s);
        end
    end

    // A load in EX whose destination feeds the instruction in ID.
    assign load_use_hit = ex_s.valid && ex_s.memread && (ex_s.rd != '0) && id_valid &&
                          ((ex_s.rd == id_rs1) || (ex_s.rd == id_rs2));

    // FSM state and down-counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state and stall/bubble/flush; a taken branch outranks a stall.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        stall_c  = 1'b0;
        bubble_c = 1'b0;
        flush_c  = 1'b0;
        if (quiet) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ex_branch_taken) begin
                        flush_c  = 1'b1;
                        bubble_c = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_n = ST_FLUSH;
                            cnt_n   = CNT_W'(FLUSH_CYCLES - 1);
                        end
                    end else if (load_use_hit) begin
                        stall_c  = 1'b1;
                        bubble_c = 1'b1;
                        if (LOAD_USE_STALL > 1) begin
                            state_n = ST_STALL;
                            cnt_n   = CNT_W'(LOAD_USE_STALL - 1);
                        end
                    end
                end
                ST_STALL: begin
                    if (ex_branch_taken) begin
                        flush_c  = 1'b1;
                        bubble_c = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_n = ST_FLUSH;
                            cnt_n   = CNT_W'(FLUSH_CYCLES - 1);
                        end else begin
                            state_n = ST_IDLE;
                            cnt_n   = '0;
                        end
                    end else begin
                        stall_c  = 1'b1;
                        bubble_c = 1'b1;
                        cnt_n    = cnt - 1'b1;
                        if (cnt == CNT_W'(1))
                            state_n = ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                    cnt_n    = cnt - 1'b1;
                    if (cnt == CNT_W'(1))
                        state_n = ST_IDLE;
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    assign fwd_a_sel = quiet ? FWD_RF : fwd_a_c;
    assign fwd_b_sel = quiet ? FWD_RF : fwd_b_c;
    assign stall     = stall_c;
    assign bubble    = bubble_c;
    assign flush     = flush_c;

`ifdef HAZARD_STATS_EN
    // Saturating per-cycle event counters, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
            fwd_count   <= '0;
        end else begin
            stall_count <= sat_inc(stall_count, stall_c);
            flush_count <= sat_inc(flush_count, flush_c);
            fwd_count   <= sat_inc(fwd_count, (fwd_a_sel != FWD_RF) || (fwd_b_sel != FWD_RF));
        end
    end
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: drives two controllers (stall/flush lengths 1/1 and 3/2)
// with the same instruction stream and checks every cycle against a reference
// model. HAZARD_STATS_EN also checks the event counters.
`timescale 1ns/1ps
module tb_hazard_fwd_ctrl;

    localparam int AW  = 5;
    localparam int L_A = 1;
    localparam int F_A = 1;
    localparam int L_B = 3;
    localparam int F_B = 2;
`ifdef HAZARD_STATS_EN
    localparam int RESP_W = 7 + 96;
`else
    localparam int RESP_W = 7;
`endif

    typedef struct packed {
        logic          v;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [AW-1:0] rd;
        logic          rw;
        logic          mr;
    } slot_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          id_valid;
    logic [AW-1:0] id_rs1;
    logic [AW-1:0] id_rs2;
    logic [AW-1:0] id_rd;
    logic          id_regwrite;
    logic          id_memread;
    logic          ex_branch_taken;

    logic [1:0] a_fa, a_fb, b_fa, b_fb;
    logic       a_st, a_bu, a_fl, b_st, b_bu, b_fl;
    logic [RESP_W-1:0] a_resp, b_resp;
`ifdef HAZARD_STATS_EN
    logic [31:0] a_sc, a_fc, a_wc, b_sc, b_fc, b_wc;
    assign a_resp = {a_fa, a_fb, a_st, a_bu, a_fl, a_sc, a_fc, a_wc};
    assign b_resp = {b_fa, b_fb, b_st, b_bu, b_fl, b_sc, b_fc, b_wc};
`else
    assign a_resp = {a_fa, a_fb, a_st, a_bu, a_fl};
    assign b_resp = {b_fa, b_fb, b_st, b_bu, b_fl};
`endif

    hazard_fwd_ctrl #(.REG_ADDR_W(AW), .LOAD_USE_STALL(L_A), .FLUSH_CYCLES(F_A)) dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_branch_taken(ex_branch_taken), .fwd_a_sel(a_fa), .fwd_b_sel(a_fb),
        .stall(a_st), .bubble(a_bu), .flush(a_fl)
`ifdef HAZARD_STATS_EN
       ,.stall_count(a_sc), .flush_count(a_fc), .fwd_count(a_wc)
`endif
    );

    hazard_fwd_ctrl #(.REG_ADDR_W(AW), .LOAD_USE_STALL(L_B), .FLUSH_CYCLES(F_B)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_branch_taken(ex_branch_taken), .fwd_a_sel(b_fa), .fwd_b_sel(b_fb),
        .stall(b_st), .bubble(b_bu), .flush(b_fl)
`ifdef HAZARD_STATS_EN
       ,.stall_count(b_sc), .flush_count(b_fc), .fwd_count(b_wc)
`endif
    );

    // ---------------- reference model ----------------
    slot_t       m_ex[2];
    slot_t       m_mem[2];
    slot_t       m_wb[2];
    int          stall_left[2];
    int          flush_left[2];
    logic [31:0] c_st[2];
    logic [31:0] c_fl[2];
    logic [31:0] c_fw[2];
    logic        m_rst_prev;

    // Youngest older writer of rs wins; x0 and empty EX never forward.
    function automatic logic [1:0] ref_src(input slot_t ex, input slot_t mem,
                                           input slot_t wb, input logic [AW-1:0] rs);
        slot_t      older[2];
        logic [1:0] code[2];
        if (!ex.v || rs == '0) return 2'b00;
        older[0] = mem; code[0] = 2'b10;
        older[1] = wb;  code[1] = 2'b01;
        for (int i = 0; i < 2; i++)
            if (older[i].v && older[i].rw && older[i].rd == rs) return code[i];
        return 2'b00;
    endfunction

    // One clock of controller k: produce this cycle's outputs, then advance.
    task automatic model_cycle(input int k, output logic [RESP_W-1:0] resp);
        logic [1:0] fa, fb;
        logic       st, bu, fl, hit, quiet;
        int         lus, fcy;
        lus = (k == 0) ? L_A : L_B;
        fcy = (k == 0) ? F_A : F_B;
        fa = 2'b00; fb = 2'b00; st = 1'b0; bu = 1'b0; fl = 1'b0;
        quiet = rst || m_rst_prev;
        hit = m_ex[k].v && m_ex[k].mr && (m_ex[k].rd != '0) && id_valid &&
              (m_ex[k].rd == id_rs1 || m_ex[k].rd == id_rs2);
        if (!quiet) begin
            fa = ref_src(m_ex[k], m_mem[k], m_wb[k], m_ex[k].rs1);
            fb = ref_src(m_ex[k], m_mem[k], m_wb[k], m_ex[k].rs2);
            if (flush_left[k] > 0) begin
                fl = 1'b1; bu = 1'b1; flush_left[k]--;
            end else if (ex_branch_taken) begin
                fl = 1'b1; bu = 1'b1; flush_left[k] = fcy - 1; stall_left[k] = 0;
            end else if (stall_left[k] > 0) begin
                st = 1'b1; bu = 1'b1; stall_left[k]--;
            end else if (hit) begin
                st = 1'b1; bu = 1'b1; stall_left[k] = lus - 1;
            end
        end
`ifdef HAZARD_STATS_EN
        resp = {fa, fb, st, bu, fl, c_st[k], c_fl[k], c_fw[k]};
`else
        resp = {fa, fb, st, bu, fl};
`endif
        if (rst) begin
            m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0;
            stall_left[k] = 0; flush_left[k] = 0;
            c_st[k] = '0; c_fl[k] = '0; c_fw[k] = '0;
        end else begin
            m_wb[k]  = m_mem[k];
            m_mem[k] = m_ex[k];
            m_ex[k]  = bu ? slot_t'('0)
                          : slot_t'({id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread});
            if (st && c_st[k] != '1) c_st[k]++;
            if (fl && c_fl[k] != '1) c_fl[k]++;
            if ((fa != 2'b00 || fb != 2'b00) && c_fw[k] != '1) c_fw[k]++;
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [2*RESP_W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    initial begin
        logic [2*RESP_W-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (a_resp !== e[2*RESP_W-1:RESP_W]) begin
                    n_fail++;
                    $display("FAIL dut_a cycle %0d: got %h expected %h", cyc, a_resp, e[2*RESP_W-1:RESP_W]);
                end
                n_tests++;
                if (b_resp !== e[RESP_W-1:0]) begin
                    n_fail++;
                    $display("FAIL dut_b cycle %0d: got %h expected %h", cyc, b_resp, e[RESP_W-1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_cycle(input logic r, input logic v, input logic [AW-1:0] s1,
                               input logic [AW-1:0] s2, input logic [AW-1:0] d,
                               input logic rw, input logic mr, input logic br, input logic check);
        logic [RESP_W-1:0] ra, rb;
        rst = r; id_valid = v; id_rs1 = s1; id_rs2 = s2; id_rd = d;
        id_regwrite = rw; id_memread = mr; ex_branch_taken = br;
        model_cycle(0, ra);
        model_cycle(1, rb);
        m_rst_prev = r;
        if (check) exp_q.push_back({ra, rb});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic ins(input logic [AW-1:0] s1, input logic [AW-1:0] s2, input logic [AW-1:0] d,
                       input logic rw, input logic mr, input logic br);
        drive_cycle(1'b0, 1'b1, s1, s2, d, rw, mr, br, 1'b1);
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // ---------------- stimulus and final report ----------------
    initial begin
        for (int k = 0; k < 2; k++) begin
            m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0;
            stall_left[k] = 0; flush_left[k] = 0;
            c_st[k] = '0; c_fl[k] = '0; c_fw[k] = '0;
        end
        m_rst_prev = 1'b0;
        rst = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_regwrite = 1'b0; id_memread = 1'b0; ex_branch_taken = 1'b0;
        @(posedge clk);
        #1;
        // initial reset, unchecked while state is unknown
        drive_cycle(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        // reset release plus quiet cycle
        nop(2);
        // MEM forward to operand A
        ins(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
        ins(5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0);
        nop(3);
        // MEM beats WB, then WB alone
        ins(5'd1, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0);
        ins(5'd1, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0);
        ins(5'd2, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0);
        ins(5'd1, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0);
        ins(5'd1, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0);
        ins(5'd2, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0);
        nop(3);
        // x0 never forwarded
        ins(5'd1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0);
        ins(5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
        nop(3);
        // load-use stall, consumer held in ID
        ins(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) ins(5'd3, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0);
        nop(4);
        // load-use hit together with a taken branch
        ins(5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0);
        ins(5'd4, 5'd2, 5'd6, 1'b1, 1'b0, 1'b1);
        nop(4);
        // reset in the middle of a stall
        ins(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0);
        ins(5'd3, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0);
        ins(5'd3, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b1, 5'd3, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        ins(5'd3, 5'd2, 5'd4, 1'b1, 1'b0, 1'b1);
        nop(4);
        // randomized traffic with small register range for frequent matches
        for (int i = 0; i < 3000; i++) begin
            drive_cycle(($urandom_range(0, 99) == 0),
                        ($urandom_range(0, 9) != 0),
                        AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                        AW'($urandom_range(0, 3)),
                        ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3),
                        ($urandom_range(0, 99) < 8), 1'b1);
        end
        nop(2);
        repeat (3) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
